// File: rtl/active_lamps_pkg.sv
// Shared mode codes, lamp count and ambient-level breakpoints for the lamp output stage.
package active_lamps_pkg;

  localparam int NLAMPS = 4;

  // One-hot mode codes from the mode decoder
  localparam logic [3:0] MODE_OFF    = 4'b0001;
  localparam logic [3:0] MODE_MANUAL = 4'b0010;
  localparam logic [3:0] MODE_DIM    = 4'b0100;
  localparam logic [3:0] MODE_CHASE  = 4'b1000;

  // Ambient-level breakpoints: each one reached turns off one more lamp.
  // The last one is a single value (15) that turns off every lamp.
  localparam logic [3:0] LVL_BP1 = 4'd4;
  localparam logic [3:0] LVL_BP2 = 4'd8;
  localparam logic [3:0] LVL_BP3 = 4'd12;
  localparam logic [3:0] LVL_BP4 = 4'd15;

endpackage

// File: rtl/active_lamps_level_dec.sv
// Maps the ambient level to a thermometer mask of lamps that may be lit when dimming.
module active_lamps_level_dec
  import active_lamps_pkg::*;
(
  input  logic [3:0] lenght,
  output logic [3:0] level
);

  // Brighter ambient light leaves fewer lamps enabled, always dropping from the top.
  always_comb begin
    level = 4'b0000;
    if (lenght < LVL_BP1)      level = 4'b1111;
    else if (lenght < LVL_BP2) level = 4'b0111;
    else if (lenght < LVL_BP3) level = 4'b0011;
    else if (lenght < LVL_BP4) level = 4'b0001;
    else                       level = 4'b0000;
  end

endmodule

// File: rtl/active_lamps.sv
// Lamp-control output stage: selects the lamp pattern for the current mode and registers it.
module active_lamps
  import active_lamps_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        tcode,
  input  logic [3:0]        ulight,
  input  logic [3:0]        lenght,
  output logic [NLAMPS-1:0] active_lights
);

  logic [3:0] level;
  logic [7:0] rot_wide;
  logic [3:0] rot;
  logic [3:0] next_lights;

  active_lamps_level_dec u_level_dec (
    .lenght (lenght),
    .level  (level)
  );

  // Rotate left by lenght[1:0]; doubling the pattern lets bit 3 wrap into bit 0.
  always_comb begin
    rot_wide = {ulight, ulight} << lenght[1:0];
    rot      = rot_wide[7:4];
  end

  // Mode mux; a zero or multi-hot code is treated as a fault and blanks the lamps.
  always_comb begin
    next_lights = 4'b0000;
    case (tcode)
      MODE_OFF:    next_lights = 4'b0000;
      MODE_MANUAL: next_lights = ulight;
      MODE_DIM:    next_lights = ulight & level;
      MODE_CHASE:  next_lights = rot;
      default:     next_lights = 4'b0000;
    endcase
  end

  // Output register, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active_lights <= 4'b0000;
    else        active_lights <= next_lights;
  end

endmodule

// File: tb/tb_active_lamps.sv
// Self-checking bench for active_lamps: directed cases followed by randomized traffic.
module tb_active_lamps;

  logic       clk;
  logic       rst_n;
  logic [3:0] tcode;
  logic [3:0] ulight;
  logic [3:0] lenght;
  logic [3:0] active_lights;

  int checks = 0;
  int errors = 0;

  active_lamps dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tcode         (tcode),
    .ulight        (ulight),
    .lenght        (lenght),
    .active_lights (active_lights)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: lamp count from the level bands, rotation by index arithmetic.
  function automatic logic [3:0] ref_next(input logic [3:0] t, input logic [3:0] u,
                                          input logic [3:0] len);
    logic [3:0] res;
    int lit;
    int r;
    res = 4'b0000;
    if ($countones(t) != 1) return 4'b0000;
    if (t[1]) res = u;
    else if (t[2]) begin
      if (len == 15) lit = 0;
      else           lit = 4 - int'(len) / 4;
      for (int i = 0; i < 4; i++) res[i] = u[i] && (i < lit);
    end else if (t[3]) begin
      r = int'(len) % 4;
      for (int i = 0; i < 4; i++) res[(i + r) % 4] = u[i];
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] t, input logic [3:0] u, input logic [3:0] len,
                      input string tag, input logic [3:0] exp);
    tcode  = t;
    ulight = u;
    lenght = len;
    @(posedge clk);
    @(negedge clk);
    check(tag, active_lights, exp);
  endtask

  initial begin
    logic [3:0] t, u, len;
    string tag;

    rst_n  = 1'b1;
    tcode  = 4'b0010;
    ulight = 4'b1111;
    lenght = 4'd0;
    #2 rst_n = 1'b0;
    #1 check("reset_async", active_lights, 4'b0000);
    @(negedge clk);
    check("reset_held", active_lights, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_release", active_lights, 4'b1111);

    step(4'b0001, 4'b1010, 4'd0,  "off",        4'b0000);
    step(4'b0010, 4'b1010, 4'd0,  "manual",     4'b1010);
    step(4'b0100, 4'b1010, 4'd2,  "dim_2",      4'b1010);
    step(4'b0100, 4'b1010, 4'd6,  "dim_6",      4'b0010);
    step(4'b0100, 4'b1010, 4'd11, "dim_11",     4'b0010);
    step(4'b0100, 4'b1010, 4'd14, "dim_14",     4'b0000);
    step(4'b0100, 4'b1010, 4'd15, "dim_15",     4'b0000);
    step(4'b0100, 4'b1111, 4'd12, "dim_12",     4'b0001);
    step(4'b0100, 4'b1111, 4'd3,  "dim_3",      4'b1111);
    step(4'b0100, 4'b1111, 4'd4,  "dim_4",      4'b0111);
    step(4'b0100, 4'b1111, 4'd8,  "dim_8",      4'b0011);
    step(4'b1000, 4'b1010, 4'd14, "chase_1010", 4'b1010);
    step(4'b1000, 4'b1110, 4'd14, "chase_1110", 4'b1011);
    step(4'b1000, 4'b0111, 4'd15, "chase_0111", 4'b1011);
    step(4'b1000, 4'b0001, 4'd1,  "chase_0001", 4'b0010);
    step(4'b1000, 4'b0001, 4'd0,  "chase_rot0", 4'b0001);
    step(4'b0000, 4'b1010, 4'd2,  "ill_0000",   4'b0000);
    step(4'b0010, 4'b1111, 4'd0,  "pre_ill",    4'b1111);
    step(4'b0110, 4'b1111, 4'd2,  "ill_0110",   4'b0000);
    step(4'b0010, 4'b1111, 4'd0,  "pre_ill2",   4'b1111);
    step(4'b1111, 4'b1111, 4'd2,  "ill_1111",   4'b0000);

    // Back-to-back mode changes: output follows each code after exactly one edge
    step(4'b0010, 4'b1010, 4'd6, "b2b_manual", 4'b1010);
    step(4'b0100, 4'b1010, 4'd6, "b2b_dim",    4'b0010);
    step(4'b1000, 4'b1010, 4'd6, "b2b_chase",  4'b1010);
    step(4'b0001, 4'b1010, 4'd6, "b2b_off",    4'b0000);

    // Mid-operation reset clears at once, operation resumes on the next edge
    step(4'b0010, 4'b0110, 4'd0, "pre_midrst", 4'b0110);
    rst_n = 1'b0;
    #1 check("midrst_clear", active_lights, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_resume", active_lights, 4'b0110);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) != 0) t = 4'(1 << $urandom_range(0, 3));
      else                           t = 4'($urandom());
      u   = 4'($urandom());
      len = 4'($urandom());
      tag = $sformatf("rand_%0d_t%b_u%b_l%0d", n, t, u, len);
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        #1 check("rand_rst", active_lights, 4'b0000);
        rst_n = 1'b1;
      end
      step(t, u, len, tag, ref_next(t, u, len));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/active_lamps.md
Name: active_lamps

Overview:
- Lamp-control output stage of the smart-house controller.
- Takes a one-hot mode code, a 4-bit user lamp pattern and a 4-bit ambient-light/length value.
- Produces a registered 4-bit lamp-enable vector.
- Sits between the mode decoder (driver of tcode) and the lamp drivers.

Parameters:
- NLAMPS, 4, number of lamps; the design is fixed at 4 and other values are unsupported.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- tcode  input  4  one-hot mode select: bit0 OFF, bit1 MANUAL, bit2 DIM, bit3 CHASE
- ulight  input  4  user lamp pattern, bit i = lamp i
- lenght  input  4  ambient level / rotate amount, unsigned 0..15
- active_lights  output  4  registered lamp enables, bit i drives lamp i

Behaviour:
- Clocking and reset
  - One clock domain, clk.
  - rst_n low asynchronously forces active_lights = 4'b0000. It stays 0000 while rst_n is held low.
  - Reset is released synchronously: the first update is at the first rising clk edge after rst_n goes high.
- Datapath and latency
  - Combinational next-value function, registered on every rising edge; no enable.
  - Latency is 1 cycle from an input change to active_lights.
  - Inputs are sampled every cycle; there is no handshake.
- Level thermometer L from lenght:
  - 0..3 -> 1111
  - 4..7 -> 0111
  - 8..11 -> 0011
  - 12..14 -> 0001
  - 15 -> 0000
- Next value by tcode:
  - 4'b0001 OFF -> 0000
  - 4'b0010 MANUAL -> ulight
  - 4'b0100 DIM -> ulight & L
  - 4'b1000 CHASE -> ulight rotated left by lenght[1:0] positions. Bit 3 wraps into bit 0. lenght[3:2] is ignored.
  - Any other tcode (4'b0000 or more than one bit set) -> 0000. There is no priority among bits.
- No internal state besides the output register; no state machine.
- Reset asserted mid-operation clears the output immediately. Normal operation resumes on the first edge after release.
- All arithmetic is 4-bit unsigned. No overflow is possible.

Decomposition:
- Package active_lamps_pkg holds:
  - MODE_OFF = 4'b0001, MODE_MANUAL = 4'b0010, MODE_DIM = 4'b0100, MODE_CHASE = 4'b1000
  - NLAMPS = 4
  - a function or localparam table for the thermometer breakpoints (4, 8, 12, 15)
- One sub-module is natural: active_lamps_level_dec. It is combinational, maps lenght[3:0] to L[3:0], and is instantiated once.
- Mode mux, rotate and the output register live in the top module active_lamps.

Test Plan:
- Reset: rst_n=0 with tcode=0010, ulight=1111 -> active_lights=0000 immediately, no clock edge needed. Release rst_n, then one edge -> 1111.
- OFF/MANUAL: tcode=0001, ulight=1010 -> 0000 after one edge. tcode=0010, ulight=1010 -> 1010 after one edge.
- DIM sweep, ulight=1010:
  - lenght=2 -> 1010
  - lenght=6 -> 0010
  - lenght=11 -> 0010
  - lenght=14 -> 0000
  - lenght=15 -> 0000
  - also ulight=1111 with lenght=12 -> 0001
- CHASE rotate/wrap:
  - ulight=1010, lenght=14 (rot 2) -> 1010
  - ulight=1110, lenght=14 (rot 2) -> 1011
  - ulight=0111, lenght=15 (rot 3) -> 1011
  - ulight=0001, lenght=1 -> 0010
- Illegal codes: tcode=0000, ulight=1010, lenght=2 -> 0000. tcode=0110 or 1111 with ulight=1111 -> 0000.
- Latency/back-to-back: change tcode every cycle MANUAL->DIM->CHASE->OFF with ulight=1010, lenght=6. Output lags by exactly one edge: 1010, 0010, 1010, 0000.
